inc_arbiter: RTL and testbench

INC_ARBITER -- requirements
Module: inc_arbiter

---
 rtl/inc_arbiter_pkg.sv | 24 ++
 rtl/inc_arbiter_rr_pick2.sv | 27 ++
 rtl/inc_arbiter.sv | 138 +++++++++++++
 tb/tb_inc_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/inc_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// inc_arbiter_pkg
// Shared definitions for the two-requester increment/load arbiter:
//   - state_e       : arbiter FSM states (idle, grant, exec, gap)
//   - OP_INC/OP_LOAD: per-requester operation encoding on op[i]
//   - DEFAULT_WIDTH : default width of the shared count register
//   - GAP_CNT_W     : width of the post-commit idle-gap counter (GAP 0..15)
// ---------------------------------------------------------------------------
package inc_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_EXEC  = 2'd2,
        S_GAP   = 2'd3
    } state_e;

    localparam logic OP_INC  = 1'b0;
    localparam logic OP_LOAD = 1'b1;

    localparam int DEFAULT_WIDTH = 13;
    localparam int GAP_CNT_W     = 4;

endpackage

// File: rtl/inc_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin winner selection (purely combinational).
// Ports:
//   req  [1:0] : level requests
//   last       : index of the requester served last
//   win  [1:0] : one-hot winner, zero when no request is present
// A lone request always wins; on contention the requester that was not
// served last wins.
// ---------------------------------------------------------------------------
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = last ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/inc_arbiter.sv
// ---------------------------------------------------------------------------
// inc_arbiter
// Round-robin arbiter letting two requesters increment or load one shared
// count register. Each accepted request runs IDLE -> GRANT -> EXEC, then
// GAP idle cycles before the next arbitration.
// Parameters:
//   WIDTH : width of the shared count register
//   GAP   : idle cycles after each commit (0..15)
// Ports:
//   n0        : clock, rising edge
//   n1        : synchronous active-high reset
//   req  [1:0]: level requests
//   op   [1:0]: per-requester operation (OP_INC / OP_LOAD)
//   ld_a, ld_b: load values for requester 0 / 1
//   gnt  [1:0]: one-hot grant, high only in GRANT
//   done      : one-cycle pulse in the cycle after a commit (EXEC)
//   cnt       : shared count register
//   busy      : high in every state except IDLE
// Build option: define INC_ARBITER_SAT_EN to make increments saturate at
// all-ones instead of wrapping to zero.
// ---------------------------------------------------------------------------
module inc_arbiter
    import inc_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GAP   = 2
) (
    input  logic             n0,
    input  logic             n1,
    input  logic [1:0]       req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] ld_a,
    input  logic [WIDTH-1:0] ld_b,
    output logic [1:0]       gnt,
    output logic             done,
    output logic [WIDTH-1:0] cnt,
    output logic             busy
);

    localparam logic [WIDTH-1:0]     ONE      = WIDTH'(1);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [1:0]             winner_q, winner_d;
    logic                   ptr_q, ptr_d;     // index of requester served last
    logic [GAP_CNT_W-1:0]   gap_q, gap_d;

    logic [1:0]             pick;
    logic                   sel_op;
    logic [WIDTH-1:0]       sel_ld;
    logic [WIDTH-1:0]       inc_val;

    rr_pick2 u_pick (
        .req  (req),
        .last (ptr_q),
        .win  (pick)
    );

    // Operation and load data come from whoever holds the grant.
    assign sel_op = winner_q[1] ? op[1] : op[0];
    assign sel_ld = winner_q[1] ? ld_b  : ld_a;

`ifdef INC_ARBITER_SAT_EN
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    assign inc_val = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + ONE;
`else
    assign inc_val = cnt_q + ONE;
`endif

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        winner_d = winner_q;
        ptr_d    = ptr_q;
        gap_d    = gap_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    winner_d = pick;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                // Only the winner's request matters; the loser waits for IDLE.
                if (|(req & winner_q)) begin
                    state_d = S_EXEC;
                    ptr_d   = winner_q[1];
                    cnt_d   = (sel_op == OP_INC) ? inc_val : sel_ld;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (GAP == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = GAP_LAST;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge n0) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (n1) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            winner_q <= 2'b00;
            ptr_q    <= 1'b1;   // requester 0 wins the first contested grant
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            winner_q <= winner_d;
            ptr_q    <= ptr_d;
            gap_q    <= gap_d;
        end
    end

    assign gnt  = (state_q == S_GRANT) ? winner_q : 2'b00;
    assign done = (state_q == S_EXEC);
    assign busy = (state_q != S_IDLE);
    assign cnt  = cnt_q;

endmodule

// File: tb/tb_inc_arbiter.sv
// ---------------------------------------------------------------------------
// tb_inc_arbiter
// Directed bench for inc_arbiter: one instance with GAP=2 for the main
// sequences, one with GAP=0 for back-to-back commits. Inputs change 1ns
// after the rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_inc_arbiter;

    localparam int W = 13;

`ifdef INC_ARBITER_SAT_EN
    localparam logic [W-1:0] TOP_INC_EXP = 13'h1FFF;
`else
    localparam logic [W-1:0] TOP_INC_EXP = 13'h0000;
`endif

    logic         clk = 1'b0;
    logic         n1;
    logic [1:0]   req, op;
    logic [W-1:0] ld_a, ld_b;
    logic [1:0]   gnt;
    logic         done, busy;
    logic [W-1:0] cnt;

    logic [1:0]   req0;
    logic [1:0]   gnt0;
    logic         done0, busy0;
    logic [W-1:0] cnt0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    inc_arbiter #(.WIDTH(W), .GAP(2)) dut (
        .n0(clk), .n1(n1), .req(req), .op(op), .ld_a(ld_a), .ld_b(ld_b),
        .gnt(gnt), .done(done), .cnt(cnt), .busy(busy)
    );

    inc_arbiter #(.WIDTH(W), .GAP(0)) dut0 (
        .n0(clk), .n1(n1), .req(req0), .op(2'b00), .ld_a(13'h0000), .ld_b(13'h0000),
        .gnt(gnt0), .done(done0), .cnt(cnt0), .busy(busy0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        n1  = 1'b1;
        req = 2'b00;
        tick();
        n1  = 1'b0;
        check("rst_cnt",  32'(cnt),  32'h0);
        check("rst_gnt",  32'(gnt),  32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
    endtask

    // One full transaction for a single requester, then back to IDLE.
    task automatic commit(input string tag, input logic [1:0] r, input logic [1:0] o,
                          input logic [1:0] exp_gnt, input logic [W-1:0] exp_cnt);
        req = r;
        op  = o;
        tick();
        check({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        tick();
        check({tag, "_cnt"},  32'(cnt),  32'(exp_cnt));
        check({tag, "_done"}, 32'(done), 32'h1);
        req = 2'b00;
        tick();
        tick();
        tick();
        check({tag, "_idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        n1   = 1'b1;
        req  = 2'b00;
        op   = 2'b00;
        ld_a = '0;
        ld_b = '0;
        req0 = 2'b00;
        tick();
        do_reset();

        // Single increment, full latency and gap timing.
        req = 2'b01;
        op  = 2'b00;
        tick();
        check("a_gnt",      32'(gnt),  32'h1);
        check("a_busy",     32'(busy), 32'h1);
        check("a_cnt_hold", 32'(cnt),  32'h0);
        check("a_done_lo",  32'(done), 32'h0);
        tick();
        check("a_cnt",      32'(cnt),  32'h1);
        check("a_done",     32'(done), 32'h1);
        check("a_gnt_off",  32'(gnt),  32'h0);
        req = 2'b00;
        tick();
        check("a_done_one", 32'(done), 32'h0);
        check("a_gap1",     32'(busy), 32'h1);
        tick();
        check("a_gap2",     32'(busy), 32'h1);
        tick();
        check("a_idle",     32'(busy), 32'h0);

        // Load all-ones by requester 1, then increment by requester 0.
        ld_b = 13'h1FFF;
        commit("c_ldb",  2'b10, 2'b10, 2'b10, 13'h1FFF);
        commit("c_top",  2'b01, 2'b00, 2'b01, TOP_INC_EXP);
        ld_a = 13'h0A5A;
        commit("c_lda",  2'b01, 2'b01, 2'b01, 13'h0A5A);

        // Both requesters held: grants alternate starting with requester 0.
        do_reset();
        req = 2'b11;
        op  = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("b_gnt%0d", i), 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check($sformatf("b_cnt%0d", i),  32'(cnt),  32'(i + 1));
            check($sformatf("b_done%0d", i), 32'(done), 32'h1);
            tick();
            tick();
            check($sformatf("b_gap%0d", i),  32'(busy), 32'h1);
            tick();
            check($sformatf("b_idle%0d", i), 32'(busy), 32'h0);
        end

        // Reset during EXEC overrides the committed value.
        req = 2'b01;
        tick();
        check("e_gnt", 32'(gnt), 32'h1);
        tick();
        check("e_cnt5", 32'(cnt),  32'h5);
        check("e_done", 32'(done), 32'h1);
        n1 = 1'b1;
        tick();
        n1  = 1'b0;
        req = 2'b00;
        check("e_cnt",  32'(cnt),  32'h0);
        check("e_gnt0", 32'(gnt),  32'h0);
        check("e_done0", 32'(done), 32'h0);
        check("e_busy", 32'(busy), 32'h0);
        tick();
        check("e_no_done", 32'(done), 32'h0);

        // Request dropped during GRANT: abort, no commit, pointer untouched.
        req = 2'b01;
        tick();
        check("d_gnt", 32'(gnt), 32'h1);
        req = 2'b00;
        tick();
        check("d_idle", 32'(busy), 32'h0);
        check("d_done", 32'(done), 32'h0);
        check("d_cnt",  32'(cnt),  32'h0);
        tick();
        check("d_still_done", 32'(done), 32'h0);
        req = 2'b11;
        tick();
        check("d_contest_gnt", 32'(gnt), 32'h1);
        tick();
        check("d_contest_cnt", 32'(cnt), 32'h1);
        req = 2'b00;
        tick();
        tick();
        tick();
        check("d_end_idle", 32'(busy), 32'h0);

        // GAP=0 instance: EXEC returns straight to IDLE.
        check("z_cnt_start", 32'(cnt0), 32'h0);
        req0 = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("z_gnt%0d", i),  32'(gnt0),  32'h1);
            check($sformatf("z_nodone%0d", i), 32'(done0), 32'h0);
            tick();
            check($sformatf("z_done%0d", i), 32'(done0), 32'h1);
            check($sformatf("z_cnt%0d", i),  32'(cnt0),  32'(i + 1));
            tick();
            check($sformatf("z_idle%0d", i), 32'(busy0), 32'h0);
            check($sformatf("z_off%0d", i),  32'(done0), 32'h0);
        end
        req0 = 2'b00;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
